// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, forward-select encoding and register-match helper
package cpu_pkg;

   localparam int XLEN   = 32;
   localparam int CTRL_W = 8;
   localparam int CNT_W  = 32;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Operand source for the EX capture muxes
   typedef enum logic [1:0] {
      FWD_ID  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   // A producer hits a source only when it really writes a non-zero register
   function automatic logic rd_match(input logic [4:0] rs, input logic [4:0] rd, input logic we);
      return we && (rd != REG_ZERO) && (rs == rd);
   endfunction

endpackage

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - RAW hazard detection and operand forward selects (FORWARDING_EN)
module hazard_unit
   import cpu_pkg::*;
(
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic [4:0] ex_rd,
   input  logic       ex_we,
   input  logic [4:0] mem_rd,
   input  logic       mem_we,
   input  logic [4:0] wb_rd,
   input  logic       wb_we,
   input  logic [4:0] hold_rs1,
   input  logic [4:0] hold_rs2,
   output logic       hazard,
   output fwd_sel_e   fwd1,
   output fwd_sel_e   fwd2,
   output logic       refresh1,
   output logic       refresh2
);

   logic ex_hit;

   // ex_we is already qualified by the caller (valid, and load-only when forwarding)
   assign ex_hit = rd_match(id_rs1, ex_rd, ex_we) || rd_match(id_rs2, ex_rd, ex_we);

   // A WB write retiring while EX is held must land in the held operands
   assign refresh1 = rd_match(hold_rs1, wb_rd, wb_we);
   assign refresh2 = rd_match(hold_rs2, wb_rd, wb_we);

`ifdef FORWARDING_EN
   // MEM is younger than WB, so its value wins when both hit
   function automatic fwd_sel_e pick(input logic [4:0] rs);
      if (rd_match(rs, mem_rd, mem_we))
         return FWD_MEM;
      else if (rd_match(rs, wb_rd, wb_we))
         return FWD_WB;
      else
         return FWD_ID;
   endfunction

   // Only a load in EX cannot be forwarded in time
   assign hazard = id_valid && ex_hit;
   assign fwd1   = pick(id_rs1);
   assign fwd2   = pick(id_rs2);
`else
   logic mem_hit;

   assign mem_hit = rd_match(id_rs1, mem_rd, mem_we) || rd_match(id_rs2, mem_rd, mem_we);

   // Without bypass paths any EX or MEM producer stalls; WB is bypassed by the register file
   assign hazard = id_valid && (ex_hit || mem_hit);
   assign fwd1   = FWD_ID;
   assign fwd2   = FWD_ID;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with stall, bubble and flush control (FORWARDING_EN)
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int XLEN   = cpu_pkg::XLEN,
   parameter int CTRL_W = cpu_pkg::CTRL_W,
   parameter int CNT_W  = cpu_pkg::CNT_W
)(
   input  logic              clk,
   input  logic              SYS_reset_n,
   input  logic              ID_valid,
   input  logic [XLEN-1:0]   ID_pc,
   input  logic [XLEN-1:0]   ID_imm,
   input  logic [4:0]        ID_rs1,
   input  logic [4:0]        ID_rs2,
   input  logic [4:0]        ID_rd,
   input  logic              ID_reg_write,
   input  logic              ID_is_load,
   input  logic [CTRL_W-1:0] ID_ctrl,
   input  logic [XLEN-1:0]   ID_data1,
   input  logic [XLEN-1:0]   ID_data2,
   input  logic              EX_ready,
   input  logic              flush,
   input  logic [4:0]        MEM_rd,
   input  logic [4:0]        WB_rd,
   input  logic              MEM_reg_write,
   input  logic              WB_reg_write,
   input  logic [XLEN-1:0]   MEM_result,
   input  logic [XLEN-1:0]   WB_data,
   output logic              ID_stall,
   output logic              EX_valid,
   output logic [XLEN-1:0]   EX_pc,
   output logic [XLEN-1:0]   EX_imm,
   output logic [4:0]        EX_rs1,
   output logic [4:0]        EX_rs2,
   output logic [4:0]        EX_rd,
   output logic              EX_reg_write,
   output logic              EX_is_load,
   output logic [CTRL_W-1:0] EX_ctrl,
   output logic [XLEN-1:0]   EX_data1,
   output logic [XLEN-1:0]   EX_data2,
   output logic [CNT_W-1:0]  bubble_count
);

   logic            ex_hazard_we;
   logic            hazard;
   fwd_sel_e        fwd1;
   fwd_sel_e        fwd2;
   logic            refresh1;
   logic            refresh2;
   logic            take_bubble;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;

`ifdef FORWARDING_EN
   assign ex_hazard_we = EX_valid && EX_reg_write && EX_is_load;
`else
   assign ex_hazard_we = EX_valid && EX_reg_write;
`endif

   hazard_unit u_hazard (
      .id_valid (ID_valid),
      .id_rs1   (ID_rs1),
      .id_rs2   (ID_rs2),
      .ex_rd    (EX_rd),
      .ex_we    (ex_hazard_we),
      .mem_rd   (MEM_rd),
      .mem_we   (MEM_reg_write),
      .wb_rd    (WB_rd),
      .wb_we    (WB_reg_write),
      .hold_rs1 (EX_rs1),
      .hold_rs2 (EX_rs2),
      .hazard   (hazard),
      .fwd1     (fwd1),
      .fwd2     (fwd2),
      .refresh1 (refresh1),
      .refresh2 (refresh2)
   );

   // Flush overrides everything; otherwise back-pressure or a hazard holds the front end
   assign ID_stall    = !flush && (!EX_ready || hazard);
   assign take_bubble = !flush && EX_ready && hazard;

   // Operand capture muxes driven by the forward selects
   always_comb begin
      op1 = ID_data1;
      op2 = ID_data2;
      case (fwd1)
         FWD_MEM: op1 = MEM_result;
         FWD_WB:  op1 = WB_data;
         default: op1 = ID_data1;
      endcase
      case (fwd2)
         FWD_MEM: op2 = MEM_result;
         FWD_WB:  op2 = WB_data;
         default: op2 = ID_data2;
      endcase
   end

   // EX slot: flush kills, back-pressure holds, hazard bubbles, else capture
   always_ff @(posedge clk or negedge SYS_reset_n) begin
      if (!SYS_reset_n) begin
         EX_valid     <= 1'b0;
         EX_pc        <= '0;
         EX_imm       <= '0;
         EX_rs1       <= '0;
         EX_rs2       <= '0;
         EX_rd        <= '0;
         EX_reg_write <= 1'b0;
         EX_is_load   <= 1'b0;
         EX_ctrl      <= '0;
         EX_data1     <= '0;
         EX_data2     <= '0;
      end else if (flush) begin
         EX_valid <= 1'b0;
      end else if (!EX_ready) begin
         if (refresh1)
            EX_data1 <= WB_data;
         if (refresh2)
            EX_data2 <= WB_data;
      end else if (hazard) begin
         EX_valid     <= 1'b0;
         EX_reg_write <= 1'b0;
      end else begin
         EX_valid     <= ID_valid;
         EX_pc        <= ID_pc;
         EX_imm       <= ID_imm;
         EX_rs1       <= ID_rs1;
         EX_rs2       <= ID_rs2;
         EX_rd        <= ID_rd;
         EX_reg_write <= ID_reg_write;
         EX_is_load   <= ID_is_load;
         EX_ctrl      <= ID_ctrl;
         EX_data1     <= op1;
         EX_data2     <= op2;
      end
   end

   // Bubble counter, wraps naturally at 2^CNT_W
   always_ff @(posedge clk or negedge SYS_reset_n) begin
      if (!SYS_reset_n)
         bubble_count <= '0;
      else if (take_bubble)
         bubble_count <= bubble_count + CNT_W'(1);
   end

endmodule
